// File: rtl/saph_trz_rasterizer_mp_if.sv
// Shape-input and pixel-group-output handshakes of the multi-lane trapezoid rasterizer.
// The master side feeds shapes and consumes groups; the slave side is the rasterizer.
interface saph_trz_rasterizer_mp_if #(
  parameter int LANES   = 4,
  parameter int COORD_W = 16,
  parameter int FRAC    = 8,
  parameter int COL_W   = 32
);
  localparam int XW = COORD_W + FRAC + 1;

  logic                 in_trig;
  logic                 in_ready;
  logic [COORD_W-1:0]   in_y_top;
  logic [COORD_W-1:0]   in_y_bot;
  logic signed [XW-1:0] in_xl;
  logic signed [XW-1:0] in_xr;
  logic signed [XW-1:0] in_dxl;
  logic signed [XW-1:0] in_dxr;
  logic [COL_W-1:0]     in_color;
  logic [COORD_W-1:0]   in_sc_x0;
  logic [COORD_W-1:0]   in_sc_x1;
  logic [COORD_W-1:0]   in_sc_y0;
  logic [COORD_W-1:0]   in_sc_y1;
  logic                 out_trig;
  logic [COORD_W-1:0]   out_x;
  logic [COORD_W-1:0]   out_y;
  logic [LANES-1:0]     out_mask;
  logic [COL_W-1:0]     out_color;
  logic                 out_ready;

  modport master (
    output in_trig, in_y_top, in_y_bot, in_xl, in_xr, in_dxl, in_dxr, in_color,
           in_sc_x0, in_sc_x1, in_sc_y0, in_sc_y1, out_ready,
    input  in_ready, out_trig, out_x, out_y, out_mask, out_color
  );

  modport slave (
    input  in_trig, in_y_top, in_y_bot, in_xl, in_xr, in_dxl, in_dxr, in_color,
           in_sc_x0, in_sc_x1, in_sc_y0, in_sc_y1, out_ready,
    output in_ready, out_trig, out_x, out_y, out_mask, out_color
  );
endinterface

// File: rtl/saph_trz_rasterizer_mp.sv
// Fixed-point trapezoid rasterizer: walks rows of a horizontal-edged trapezoid and
// emits LANES-aligned pixel groups with a coverage mask, clipped to a scissor box.
module saph_trz_rasterizer_mp #(
  parameter int LANES   = 4,
  parameter int COORD_W = 16,
  parameter int FRAC    = 8,
  parameter int COL_W   = 32
) (
  input logic                   clk,
  input logic                   rst,
  saph_trz_rasterizer_mp_if.slave bus
);
  localparam int AW = COORD_W + FRAC + 3;
  localparam int PW = COORD_W + 1;
  localparam logic signed [AW-1:0] ROUND_UP  = AW'((64'd1 << FRAC) - 64'd1);
  localparam logic [COORD_W-1:0]   LANE_LO   = COORD_W'(LANES - 1);
  localparam logic [PW-1:0]        LANE_STEP = PW'(LANES);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, EMIT = 2'd2, NEXT = 2'd3} state_t;

  state_t                state_r, state_nxt_s;
  logic signed [AW-1:0]  xl_r, xr_r, dxl_r, dxr_r;
  logic [COORD_W-1:0]    y_r, y_bot_r, sc_x0_r, sc_x1_r, sc_y0_r, sc_y1_r;
  logic [COORD_W-1:0]    span_xs_r, span_xe_r, gx_r;
  logic                  in_ready_r, out_trig_r;
  logic [COORD_W-1:0]    out_x_r, out_y_r;
  logic [LANES-1:0]      out_mask_r;
  logic [COL_W-1:0]      out_color_r;

  logic signed [AW-1:0]  ceil_xl_s, ceil_xr_s, sc_x0_s, sc_x1_s, xs_s, xe_min_s, xe_s;
  logic [COORD_W-1:0]    clip_xs_s, clip_xe_s, first_gx_s;
  logic [PW-1:0]         gx_step_s;
  logic                  span_ok_s, more_s, accept_s, y_last_s;

  // Ceiling of a fixed-point edge position, i.e. the first pixel centre at or right of it.
  function automatic logic signed [AW-1:0] ceil_int(input logic signed [AW-1:0] v);
    ceil_int = (v + ROUND_UP) >>> FRAC;
  endfunction

  function automatic logic [LANES-1:0] group_mask(input logic [COORD_W-1:0] gx,
                                                  input logic [COORD_W-1:0] xs,
                                                  input logic [COORD_W-1:0] xe);
    logic [PW-1:0] px;
    group_mask = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      px = {1'b0, gx} + PW'(i);
      group_mask[i] = (px >= {1'b0, xs}) && (px < {1'b0, xe});
    end
  endfunction

  // Clipped span of the current row plus group-walk and handshake qualifiers.
  always_comb begin
    sc_x0_s    = AW'(sc_x0_r);
    sc_x1_s    = AW'(sc_x1_r);
    ceil_xl_s  = ceil_int(xl_r);
    ceil_xr_s  = ceil_int(xr_r);
    xs_s       = (ceil_xl_s < sc_x0_s) ? sc_x0_s : ceil_xl_s;
    xe_min_s   = (ceil_xr_s > sc_x1_s) ? sc_x1_s : ceil_xr_s;
    xe_s       = xe_min_s[AW-1] ? {AW{1'b0}} : xe_min_s;
    span_ok_s  = (y_r >= sc_y0_r) && (y_r < sc_y1_r) && (xs_s < xe_s) &&
                 (xs_s[AW-1:COORD_W] == {(AW-COORD_W){1'b0}}) &&
                 (xe_s[AW-1:COORD_W] == {(AW-COORD_W){1'b0}});
    clip_xs_s  = xs_s[COORD_W-1:0];
    clip_xe_s  = xe_s[COORD_W-1:0];
    first_gx_s = clip_xs_s & ~LANE_LO;
    gx_step_s  = {1'b0, gx_r} + LANE_STEP;
    more_s     = gx_step_s < {1'b0, span_xe_r};
    accept_s   = bus.in_trig && in_ready_r && (state_r == IDLE);
    y_last_s   = (y_r + COORD_W'(1)) == y_bot_r;
  end

  // Next-state decision of the row walker.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (bus.in_y_top < bus.in_y_bot)) state_nxt_s = SETUP;
        else                                           state_nxt_s = IDLE;
      end
      SETUP: begin
        if (span_ok_s) state_nxt_s = EMIT;
        else           state_nxt_s = NEXT;
      end
      EMIT: begin
        if (bus.out_ready && !more_s) state_nxt_s = NEXT;
        else                          state_nxt_s = EMIT;
      end
      NEXT: begin
        if (y_last_s) state_nxt_s = IDLE;
        else          state_nxt_s = SETUP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Shape capture, edge stepping and registered group outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_trig_r  <= 1'b0;
      out_x_r     <= {COORD_W{1'b0}};
      out_y_r     <= {COORD_W{1'b0}};
      out_mask_r  <= {LANES{1'b0}};
      out_color_r <= {COL_W{1'b0}};
      xl_r        <= {AW{1'b0}};
      xr_r        <= {AW{1'b0}};
      dxl_r       <= {AW{1'b0}};
      dxr_r       <= {AW{1'b0}};
      y_r         <= {COORD_W{1'b0}};
      y_bot_r     <= {COORD_W{1'b0}};
      sc_x0_r     <= {COORD_W{1'b0}};
      sc_x1_r     <= {COORD_W{1'b0}};
      sc_y0_r     <= {COORD_W{1'b0}};
      sc_y1_r     <= {COORD_W{1'b0}};
      span_xs_r   <= {COORD_W{1'b0}};
      span_xe_r   <= {COORD_W{1'b0}};
      gx_r        <= {COORD_W{1'b0}};
    end else begin
      // Ready lags the return to IDLE by one cycle and drops on the accepting edge.
      in_ready_r <= (state_r == IDLE) && !accept_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            xl_r        <= AW'(bus.in_xl);
            xr_r        <= AW'(bus.in_xr);
            dxl_r       <= AW'(bus.in_dxl);
            dxr_r       <= AW'(bus.in_dxr);
            y_r         <= bus.in_y_top;
            y_bot_r     <= bus.in_y_bot;
            sc_x0_r     <= bus.in_sc_x0;
            sc_x1_r     <= bus.in_sc_x1;
            sc_y0_r     <= bus.in_sc_y0;
            sc_y1_r     <= bus.in_sc_y1;
            out_color_r <= bus.in_color;
          end
        end
        SETUP: begin
          if (span_ok_s) begin
            span_xs_r  <= clip_xs_s;
            span_xe_r  <= clip_xe_s;
            gx_r       <= first_gx_s;
            out_x_r    <= first_gx_s;
            out_y_r    <= y_r;
            out_mask_r <= group_mask(first_gx_s, clip_xs_s, clip_xe_s);
            out_trig_r <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (more_s) begin
              gx_r       <= gx_step_s[COORD_W-1:0];
              out_x_r    <= gx_step_s[COORD_W-1:0];
              out_mask_r <= group_mask(gx_step_s[COORD_W-1:0], span_xs_r, span_xe_r);
            end else begin
              out_trig_r <= 1'b0;
            end
          end
        end
        NEXT: begin
          xl_r <= xl_r + dxl_r;
          xr_r <= xr_r + dxr_r;
          y_r  <= y_r + COORD_W'(1);
        end
        default: out_trig_r <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_trig  = out_trig_r;
  assign bus.out_x     = out_x_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_mask  = out_mask_r;
  assign bus.out_color = out_color_r;
endmodule

// File: tb/tb_saph_trz_rasterizer_mp.sv
// Scoreboard bench for saph_trz_rasterizer_mp: directed shapes plus random shapes checked
// against a row-by-row arithmetic model of the coverage and scissor rules.
module tb_saph_trz_rasterizer_mp;
  localparam int LANES = 4, COORD_W = 16, FRAC = 8, COL_W = 32;
  localparam int XW = COORD_W + FRAC + 1;

  typedef struct {
    longint y_top, y_bot, xl, xr, dxl, dxr, sx0, sx1, sy0, sy1;
    logic [COL_W-1:0] color;
  } shape_t;

  typedef struct {
    longint x, y;
    logic [LANES-1:0] mask;
    logic [COL_W-1:0] color;
  } grp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  grp_t exp_q[$];
  grp_t held;
  bit held_vld = 1'b0;
  bit rand_ready = 1'b0;
  bit stall_arm = 1'b0;
  int stall_cnt = 0;

  saph_trz_rasterizer_mp_if #(.LANES(LANES), .COORD_W(COORD_W), .FRAC(FRAC), .COL_W(COL_W)) bus ();
  saph_trz_rasterizer_mp #(.LANES(LANES), .COORD_W(COORD_W), .FRAC(FRAC), .COL_W(COL_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_grp(longint x, longint y, logic [LANES-1:0] m, logic [COL_W-1:0] c);
    grp_t g;
    g.x = x; g.y = y; g.mask = m; g.color = c;
    exp_q.push_back(g);
  endfunction

  // Reference: each row's edges evaluated directly from the top-row value and slope.
  function automatic void model_shape(shape_t s);
    longint xl, xr, xs, xe;
    grp_t g;
    for (longint y = s.y_top; y < s.y_bot; y++) begin
      xl = s.xl + (y - s.y_top) * s.dxl;
      xr = s.xr + (y - s.y_top) * s.dxr;
      xs = (xl + (longint'(1) << FRAC) - 1) >>> FRAC;
      xe = (xr + (longint'(1) << FRAC) - 1) >>> FRAC;
      if (xs < s.sx0) xs = s.sx0;
      if (xe > s.sx1) xe = s.sx1;
      if (xe < 0) xe = 0;
      if (y < s.sy0 || y >= s.sy1 || xs >= xe) continue;
      for (longint gx = (xs / LANES) * LANES; gx < xe; gx += LANES) begin
        g.x = gx; g.y = y; g.color = s.color;
        for (int i = 0; i < LANES; i++) g.mask[i] = (gx + i >= xs) && (gx + i < xe);
        exp_q.push_back(g);
      end
    end
  endfunction

  function automatic shape_t mk(longint yt, longint yb, longint xl, longint xr,
                                longint dxl, longint dxr, logic [COL_W-1:0] c);
    shape_t s;
    s.y_top = yt; s.y_bot = yb; s.xl = xl; s.xr = xr; s.dxl = dxl; s.dxr = dxr;
    s.sx0 = 0; s.sx1 = 65535; s.sy0 = 0; s.sy1 = 65535; s.color = c;
    return s;
  endfunction

  task automatic send(input shape_t s);
    int n = 0;
    while (!bus.in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) chk("in_ready_wait", 0, 1);
    bus.in_y_top = COORD_W'(s.y_top); bus.in_y_bot = COORD_W'(s.y_bot);
    bus.in_xl = XW'(s.xl);   bus.in_xr = XW'(s.xr);
    bus.in_dxl = XW'(s.dxl); bus.in_dxr = XW'(s.dxr);
    bus.in_sc_x0 = COORD_W'(s.sx0); bus.in_sc_x1 = COORD_W'(s.sx1);
    bus.in_sc_y0 = COORD_W'(s.sy0); bus.in_sc_y1 = COORD_W'(s.sy1);
    bus.in_color = s.color;
    bus.in_trig = 1'b1;
    @(posedge clk); #1;
    bus.in_trig = 1'b0;
    // Garbage after accept must not disturb the shape in flight.
    bus.in_xl = XW'($urandom); bus.in_xr = XW'($urandom);
    bus.in_dxl = XW'($urandom); bus.in_dxr = XW'($urandom);
    bus.in_y_bot = COORD_W'($urandom); bus.in_sc_x0 = COORD_W'($urandom);
    bus.in_sc_x1 = COORD_W'($urandom); bus.in_color = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!(bus.in_ready && exp_q.size() == 0) && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 2000) chk("drain_timeout", cyc, 0);
    chk("groups_outstanding", exp_q.size(), 0);
  endtask

  // Consumer: ready is full-rate, random, or a one-shot 3-cycle stall on group (4,1111).
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      stall_cnt--;
      bus.out_ready = 1'b0;
    end else if (stall_arm && bus.out_trig && bus.out_x == 16'd4 && bus.out_mask == 4'b1111) begin
      stall_arm = 1'b0;
      stall_cnt = 2;
      bus.out_ready = 1'b0;
    end else if (rand_ready) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  // Monitor: hold-stability under backpressure and in-order scoreboard on each handshake.
  always @(negedge clk) begin
    grp_t e;
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        checks++;
        if (!bus.out_trig || bus.out_x != held.x || bus.out_y != held.y ||
            bus.out_mask != held.mask || bus.out_color != held.color) begin
          errors++;
          $display("FAIL hold_stable: got trig=%0b x=%0d y=%0d mask=%b color=%h expected x=%0d y=%0d mask=%b color=%h",
                   bus.out_trig, bus.out_x, bus.out_y, bus.out_mask, bus.out_color,
                   held.x, held.y, held.mask, held.color);
        end
      end
      held_vld = bus.out_trig && !bus.out_ready;
      if (held_vld) begin
        held.x = bus.out_x; held.y = bus.out_y; held.mask = bus.out_mask; held.color = bus.out_color;
      end
      if (bus.out_trig && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_group: got x=%0d y=%0d mask=%b expected none",
                   bus.out_x, bus.out_y, bus.out_mask);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_x != e.x || bus.out_y != e.y || bus.out_mask != e.mask || bus.out_color != e.color) begin
            errors++;
            $display("FAIL group: got x=%0d y=%0d mask=%b color=%h expected x=%0d y=%0d mask=%b color=%h",
                     bus.out_x, bus.out_y, bus.out_mask, bus.out_color, e.x, e.y, e.mask, e.color);
          end
        end
      end
    end
  end

  initial begin
    shape_t s;
    int cyc, n;
    bus.in_trig = 1'b0; bus.out_ready = 1'b1;
    bus.in_y_top = '0; bus.in_y_bot = '0; bus.in_xl = '0; bus.in_xr = '0;
    bus.in_dxl = '0; bus.in_dxr = '0; bus.in_color = '0;
    bus.in_sc_x0 = '0; bus.in_sc_x1 = '0; bus.in_sc_y0 = '0; bus.in_sc_y1 = '0;

    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_trig", bus.out_trig, 0);
    chk("rst_outputs", {bus.out_x, bus.out_y, bus.out_mask, bus.out_color}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", bus.in_ready, 1);

    // Rectangle with a 3-cycle stall on (4,1111) of the first row.
    s = mk(2, 4, 'h300, 'h900, 0, 0, 32'hCAFE0001);
    for (int y = 2; y < 4; y++) begin
      push_grp(0, y, 4'b1000, s.color); push_grp(4, y, 4'b1111, s.color); push_grp(8, y, 4'b0001, s.color);
    end
    stall_arm = 1'b1;
    send(s); wait_done(cyc);
    chk("stall_taken", stall_arm, 0);

    s = mk(0, 4, 0, 'h400, 'h080, 0, 32'h5107E000);
    push_grp(0, 0, 4'b1111, s.color); push_grp(0, 1, 4'b1110, s.color);
    push_grp(0, 2, 4'b1110, s.color); push_grp(0, 3, 4'b1100, s.color);
    send(s); wait_done(cyc);

    s = mk(2, 4, 'h300, 'h900, 0, 0, 32'h5C155000);
    s.sx0 = 4; s.sx1 = 8; s.sy0 = 3; s.sy1 = 10;
    push_grp(4, 3, 4'b1111, s.color);
    send(s); wait_done(cyc);

    s = mk(5, 5, 'h100, 'h900, 0, 0, 32'h0);
    send(s); wait_done(cyc);
    chk("degenerate_ready_cycles", cyc, 1);

    s = mk(10, 13, 'h800, 'h200, 0, 0, 32'h0);
    send(s); wait_done(cyc);
    chk("empty_rows_cycles", cyc, 7);

    // Reset while groups are streaming, then a clean shape.
    s = mk(2, 6, 0, 'h4000, 0, 0, 32'hDEAD0000);
    model_shape(s);
    send(s);
    n = 0;
    while (!bus.out_trig && n < 100) begin @(posedge clk); #1; n++; end
    chk("mid_shape_trig", bus.out_trig, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_trig", bus.out_trig, 0);
    chk("midrst_outputs", {bus.out_x, bus.out_y, bus.out_mask, bus.out_color}, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_after", bus.in_ready, 1);
    s = mk(2, 4, 'h300, 'h900, 0, 0, 32'h600DF00D);
    model_shape(s);
    send(s); wait_done(cyc);

    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s.y_top = $urandom_range(0, 30);
      s.y_bot = s.y_top + $urandom_range(0, 5);
      s.xl = longint'($urandom_range(0, 'h3000)) - 1024;
      s.xr = s.xl + longint'($urandom_range(0, 'h1800)) - 512;
      s.dxl = longint'($urandom_range(0, 1024)) - 512;
      s.dxr = longint'($urandom_range(0, 1024)) - 512;
      if ($urandom_range(0, 1) == 0) begin
        s.sx0 = 0; s.sx1 = 65535; s.sy0 = 0; s.sy1 = 65535;
      end else begin
        s.sx0 = $urandom_range(0, 12); s.sx1 = s.sx0 + $urandom_range(0, 40);
        s.sy0 = $urandom_range(0, 15); s.sy1 = s.sy0 + $urandom_range(0, 20);
      end
      s.color = $urandom;
      model_shape(s);
      send(s); wait_done(cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
